test_scoreboard: RTL and testbench

TEST_SCOREBOARD -- requirements
Module: test_scoreboard

---
 rtl/test_scoreboard.sv | 170 +++++++++++++++++
 tb/tb_test_scoreboard.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/test_scoreboard.sv
// test_scoreboard
//
// Collects pass/fail reports from a checker and keeps the run's statistics.
// The block has three states, IDLE, RUN and DONE. A start pulse in IDLE or
// DONE clears the statistics and enters RUN. Reports are accepted only in
// RUN. The run ends on a report with rep_last set, or when the block waits
// too long between reports.
//
// Ports
//   clk, reset        single clock, synchronous active-high reset
//   start             one-cycle pulse; clears statistics and begins a run
//   rep_valid/ready   report handshake; ready is high only in RUN
//   rep_test          index of the reported test
//   rep_pass          1 = test passed
//   rep_last          final report of the run
//   pass_count        passing, in-order reports (saturating)
//   fail_count        failing or out-of-order reports (saturating)
//   first_fail(_valid) index of the first report that counted as a failure
//   seq_err           sticky; a report arrived with an unexpected index
//   timeout           sticky; the run ended because it waited too long
//   done              high while in DONE
//   all_pass          done with no failures and no timeout

`ifndef TEST_I_ADDR_WIDTH
`define TEST_I_ADDR_WIDTH 8
`endif

module test_scoreboard #(
    parameter int ADDR_W  = `TEST_I_ADDR_WIDTH,
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              rep_valid,
    output logic              rep_ready,
    input  logic [ADDR_W-1:0] rep_test,
    input  logic              rep_pass,
    input  logic              rep_last,
    output logic [CNT_W-1:0]  pass_count,
    output logic [CNT_W-1:0]  fail_count,
    output logic [ADDR_W-1:0] first_fail,
    output logic              first_fail_valid,
    output logic              seq_err,
    output logic              timeout,
    output logic              done,
    output logic              all_pass
);

    // The idle counter only has to reach TIMEOUT-1.
    localparam int IDLE_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    pass_q, pass_d;
    logic [CNT_W-1:0]    fail_q, fail_d;
    logic [ADDR_W-1:0]   ff_q, ff_d;
    logic                ffv_q, ffv_d;
    logic                seq_q, seq_d;
    logic                to_q, to_d;
    logic [IDLE_W-1:0]   idle_q, idle_d;
    logic [ADDR_W-1:0]   exp_q, exp_d;

    logic accept;
    logic mismatch;
    logic is_fail;

    assign accept   = (state_q == S_RUN) && rep_valid;
    assign mismatch = (rep_test != exp_q);
    // An out-of-order report counts as one failure, whatever rep_pass says.
    assign is_fail  = !rep_pass || mismatch;

    always_comb begin
        state_d = state_q;
        pass_d  = pass_q;
        fail_d  = fail_q;
        ff_d    = ff_q;
        ffv_d   = ffv_q;
        seq_d   = seq_q;
        to_d    = to_q;
        idle_d  = idle_q;
        exp_d   = exp_q;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                // Statistics stay frozen until the next start.
                if (start) begin
                    state_d = S_RUN;
                    pass_d  = '0;
                    fail_d  = '0;
                    ff_d    = '0;
                    ffv_d   = 1'b0;
                    seq_d   = 1'b0;
                    to_d    = 1'b0;
                    idle_d  = '0;
                    exp_d   = '0;
                end
            end

            S_RUN: begin
                if (accept) begin
                    if (is_fail) begin
                        if (fail_q != '1) fail_d = fail_q + CNT_W'(1);
                        if (!ffv_q) begin
                            ff_d  = rep_test;
                            ffv_d = 1'b1;
                        end
                    end else begin
                        if (pass_q != '1) pass_d = pass_q + CNT_W'(1);
                    end
                    if (mismatch) seq_d = 1'b1;
                    // Resynchronise on the reported index, so that a single
                    // skipped test counts as one error and not as a cascade.
                    exp_d  = rep_test + ADDR_W'(1);
                    idle_d = '0;
                    if (rep_last) state_d = S_DONE;
                end else if (idle_q == IDLE_LAST) begin
                    to_d    = 1'b1;
                    state_d = S_DONE;
                end else begin
                    idle_d = idle_q + IDLE_W'(1);
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            pass_q  <= '0;
            fail_q  <= '0;
            ff_q    <= '0;
            ffv_q   <= 1'b0;
            seq_q   <= 1'b0;
            to_q    <= 1'b0;
            idle_q  <= '0;
            exp_q   <= '0;
        end else begin
            state_q <= state_d;
            pass_q  <= pass_d;
            fail_q  <= fail_d;
            ff_q    <= ff_d;
            ffv_q   <= ffv_d;
            seq_q   <= seq_d;
            to_q    <= to_d;
            idle_q  <= idle_d;
            exp_q   <= exp_d;
        end
    end

    assign rep_ready        = (state_q == S_RUN);
    assign done             = (state_q == S_DONE);
    assign pass_count       = pass_q;
    assign fail_count       = fail_q;
    assign first_fail       = ff_q;
    assign first_fail_valid = ffv_q;
    assign seq_err          = seq_q;
    assign timeout          = to_q;
    assign all_pass         = done && (fail_q == '0) && !to_q;

endmodule

// File: tb/tb_test_scoreboard.sv
// Bench for test_scoreboard. Two instances share the stimulus: one with wide
// counters and one with 2-bit counters to exercise saturation. A behavioural
// model tracks the run and every output of both instances is compared after
// each clock edge.

module tb_test_scoreboard;

    localparam int AW = 4;
    localparam int TO = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset, start, rep_valid, rep_pass, rep_last;
    logic [AW-1:0] rep_test;

    logic          a_rdy, a_ffv, a_seq, a_to, a_done, a_all;
    logic [15:0]   a_pc, a_fc;
    logic [AW-1:0] a_ff;
    logic          b_rdy, b_ffv, b_seq, b_to, b_done, b_all;
    logic [1:0]    b_pc, b_fc;
    logic [AW-1:0] b_ff;

    test_scoreboard #(.ADDR_W(AW), .CNT_W(16), .TIMEOUT(TO)) u_a (
        .clk(clk), .reset(reset), .start(start), .rep_valid(rep_valid),
        .rep_ready(a_rdy), .rep_test(rep_test), .rep_pass(rep_pass),
        .rep_last(rep_last), .pass_count(a_pc), .fail_count(a_fc),
        .first_fail(a_ff), .first_fail_valid(a_ffv), .seq_err(a_seq),
        .timeout(a_to), .done(a_done), .all_pass(a_all)
    );

    test_scoreboard #(.ADDR_W(AW), .CNT_W(2), .TIMEOUT(TO)) u_b (
        .clk(clk), .reset(reset), .start(start), .rep_valid(rep_valid),
        .rep_ready(b_rdy), .rep_test(rep_test), .rep_pass(rep_pass),
        .rep_last(rep_last), .pass_count(b_pc), .fail_count(b_fc),
        .first_fail(b_ff), .first_fail_valid(b_ffv), .seq_err(b_seq),
        .timeout(b_to), .done(b_done), .all_pass(b_all)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: plain bookkeeping of the run.
    bit m_run, m_done, m_ffv, m_seq, m_to;
    int m_pass, m_fail, m_ff, m_exp, m_idle;

    function automatic void m_clear();
        m_pass = 0; m_fail = 0; m_ff = 0; m_ffv = 0;
        m_seq = 0; m_to = 0; m_idle = 0; m_exp = 0;
    endfunction

    function automatic void m_edge();
        bit bad;
        if (reset) begin
            m_run = 0; m_done = 0; m_clear();
        end else if (!m_run) begin
            if (start) begin
                m_run = 1; m_done = 0; m_clear();
            end
        end else if (rep_valid) begin
            bad = !rep_pass || (int'(rep_test) != m_exp);
            if (bad) begin
                m_fail++;
                if (!m_ffv) begin m_ffv = 1; m_ff = int'(rep_test); end
            end else begin
                m_pass++;
            end
            if (int'(rep_test) != m_exp) m_seq = 1;
            m_exp  = (int'(rep_test) + 1) % (1 << AW);
            m_idle = 0;
            if (rep_last) begin m_run = 0; m_done = 1; end
        end else begin
            m_idle++;
            if (m_idle == TO) begin m_to = 1; m_run = 0; m_done = 1; end
        end
    endfunction

    function automatic int sat(input int v, input int maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    task automatic check_all();
        int allp;
        allp = (m_done && m_fail == 0 && !m_to) ? 1 : 0;
        chk("a_ready", a_rdy, m_run);      chk("b_ready", b_rdy, m_run);
        chk("a_done", a_done, m_done);     chk("b_done", b_done, m_done);
        chk("a_pass", a_pc, sat(m_pass, 65535));
        chk("b_pass", b_pc, sat(m_pass, 3));
        chk("a_fail", a_fc, sat(m_fail, 65535));
        chk("b_fail", b_fc, sat(m_fail, 3));
        chk("a_ff", a_ff, m_ff);           chk("b_ff", b_ff, m_ff);
        chk("a_ffv", a_ffv, m_ffv);        chk("b_ffv", b_ffv, m_ffv);
        chk("a_seq", a_seq, m_seq);        chk("b_seq", b_seq, m_seq);
        chk("a_to", a_to, m_to);           chk("b_to", b_to, m_to);
        chk("a_allpass", a_all, allp);     chk("b_allpass", b_all, allp);
    endtask

    task automatic drive(input bit r, input bit s, input bit v, input int t,
                         input bit p, input bit l);
        reset = r; start = s; rep_valid = v; rep_test = AW'(t);
        rep_pass = p; rep_last = l;
        @(posedge clk);
        m_edge();
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        int vprob;
        int t;
        m_run = 0; m_done = 0; m_clear();
        drive(1, 0, 0, 0, 0, 0);
        drive(1, 1, 1, 3, 1, 1);   // reset beats start and valid

        // Happy path: 0..7 all pass
        drive(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) drive(0, 0, 1, i, 1, i == 7);
        chk("happy_pass", a_pc, 8);
        chk("happy_done", a_done, 1);
        chk("happy_allpass", a_all, 1);
        idle(2);

        // Failures on 2 and 4
        drive(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) drive(0, 0, 1, i, !(i == 2 || i == 4), i == 4);
        chk("fails_pass", a_pc, 3);
        chk("fails_fail", a_fc, 2);
        chk("fails_ff", a_ff, 2);
        chk("fails_ffv", a_ffv, 1);
        chk("fails_allpass", a_all, 0);

        // Sequence error: 0, 1, 3
        drive(0, 1, 0, 0, 0, 0);
        drive(0, 0, 1, 0, 1, 0);
        drive(0, 0, 1, 1, 1, 0);
        drive(0, 0, 1, 3, 1, 1);
        chk("seq_err", a_seq, 1);
        chk("seq_fail", a_fc, 1);
        chk("seq_pass", a_pc, 2);
        chk("seq_ff", a_ff, 3);

        // Timeout: one report, then TO idle cycles
        drive(0, 1, 0, 0, 0, 0);
        drive(0, 0, 1, 0, 1, 0);
        idle(TO - 1);
        chk("to_early", a_to, 0);
        idle(1);
        chk("to_flag", a_to, 1);
        chk("to_done", a_done, 1);
        chk("to_allpass", a_all, 0);
        chk("to_ready", a_rdy, 0);

        // Mid-run reset after 3 reports, then a clean run
        drive(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) drive(0, 0, 1, i, i != 1, 0);
        drive(1, 0, 1, 3, 1, 0);
        chk("rst_ready", a_rdy, 0);
        chk("rst_pass", a_pc, 0);
        chk("rst_fail", a_fc, 0);
        drive(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) drive(0, 0, 1, i, 1, i == 2);
        chk("rerun_pass", a_pc, 3);
        chk("rerun_allpass", a_all, 1);

        // Restart from DONE and saturation of the 2-bit counters
        drive(0, 1, 0, 0, 0, 0);
        chk("restart_clear", a_pc, 0);
        for (int i = 0; i < 5; i++) drive(0, 0, 1, i, 1, i == 4);
        chk("sat_b_pass", b_pc, 3);
        chk("sat_a_pass", a_pc, 5);

        // Randomised traffic with varying report density
        vprob = 50;
        for (int c = 0; c < 3000; c++) begin
            if (c % 60 == 0) begin
                case ($urandom_range(3))
                    0: vprob = 0;
                    1: vprob = 20;
                    2: vprob = 50;
                    default: vprob = 90;
                endcase
            end
            t = ($urandom_range(9) < 7) ? m_exp : int'($urandom_range((1 << AW) - 1));
            drive($urandom_range(99) == 0, $urandom_range(7) == 0,
                  $urandom_range(99) < vprob, t,
                  $urandom_range(9) < 8, $urandom_range(11) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
